// File: rtl/light_phase_timer.sv
// light_phase_timer
//   Sequences lamp patterns for an intersection: serves a green pattern for a
//   requested number of ticks, then asks upstream for the next pattern. A
//   changed pattern is separated from the old one by a yellow interval (only
//   when some field was green) and an all-red clearance interval. Re-requesting
//   the current green pattern extends the green without any yellow or all-red.
//
//   Optional feature: define LIGHT_TIMER_HOLD_EN to add the 'hold' input, which
//   freezes the GREEN interval (state and timeLeft) while high.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-low reset
//   tick       in   1  timebase enable, interval timers count only on tick=1
//   hold       in   1  (LIGHT_TIMER_HOLD_EN only) freeze GREEN interval
//   laneOutput in   8  requested pattern WWSSEENN, sampled in the nextReq cycle
//   loadTime   in   7  requested green duration in ticks (0 is served as 1)
//   nextReq    out  1  one-cycle request pulse to upstream
//   lights     out  8  lamp drive WWSSEENN, 11=green 01=yellow 00=red
//   timeLeft   out  7  ticks remaining in the current interval
module light_phase_timer #(
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
`ifdef LIGHT_TIMER_HOLD_EN
  input  logic       hold,
`endif
  input  logic [7:0] laneOutput,
  input  logic [6:0] loadTime,
  output logic       nextReq,
  output logic [7:0] lights,
  output logic [6:0] timeLeft
);

  localparam int unsigned LW = 8;
  localparam int unsigned TW = 7;

  // Lower bit of every 2-bit field; masks a green pattern down to yellow.
  localparam logic [LW-1:0] YELLOW_MASK = LW'(8'h55);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [LW-1:0] green_q, green_n;        // pattern currently (or last) shown green
  logic [LW-1:0] pend_lights_q, pend_lights_n;
  logic [TW-1:0] pend_time_q, pend_time_n;
  logic          boot_q, boot_n;          // clearance since reset already served
  logic [LW-1:0] lights_n;
  logic [TW-1:0] time_n;
  logic          next_req_n;

  logic [LW-1:0] req_pat;
  logic [TW-1:0] req_time;
  logic          hold_act;

  // Any field that is not exactly green is forced to red.
  function automatic logic [LW-1:0] sanitise(input logic [LW-1:0] pat);
    logic [LW-1:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (pat[2*i +: 2] == 2'b11) res[2*i +: 2] = 2'b11;
    end
    return res;
  endfunction

`ifdef LIGHT_TIMER_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // Request as it will be served if sampled this cycle.
  assign req_pat  = sanitise(laneOutput);
  assign req_time = (loadTime == '0) ? TW'(1) : loadTime;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_ALLRED;
      green_q       <= '0;
      pend_lights_q <= '0;
      pend_time_q   <= TW'(1);
      boot_q        <= 1'b1;
      lights        <= '0;
      timeLeft      <= TW'(ALLRED_TIME);
      nextReq       <= 1'b0;
    end else begin
      state_q       <= state_n;
      green_q       <= green_n;
      pend_lights_q <= pend_lights_n;
      pend_time_q   <= pend_time_n;
      boot_q        <= boot_n;
      lights        <= lights_n;
      timeLeft      <= time_n;
      nextReq       <= next_req_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state_q;
    green_n       = green_q;
    pend_lights_n = pend_lights_q;
    pend_time_n   = pend_time_q;
    boot_n        = boot_q;
    lights_n      = lights;
    time_n        = timeLeft;
    next_req_n    = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // tick is ignored here; the request is decided in this single cycle.
        boot_n = 1'b0;
        if (req_pat == green_q) begin
          // Green extension: same lamps, fresh duration.
          state_n  = S_GREEN;
          time_n   = req_time;
          lights_n = green_q;
        end else if (boot_q) begin
          // First request after reset: the reset all-red already cleared.
          state_n  = S_GREEN;
          green_n  = req_pat;
          lights_n = req_pat;
          time_n   = req_time;
        end else begin
          pend_lights_n = req_pat;
          pend_time_n   = req_time;
          if (green_q != '0) begin
            state_n  = S_YELLOW;
            time_n   = TW'(YELLOW_TIME);
            lights_n = green_q & YELLOW_MASK;
          end else begin
            state_n  = S_ALLRED;
            time_n   = TW'(ALLRED_TIME);
            lights_n = '0;
          end
        end
      end

      S_GREEN: begin
        if (tick && !hold_act) begin
          if (timeLeft > TW'(1)) begin
            time_n = timeLeft - TW'(1);
          end else begin
            state_n    = S_REQ;
            next_req_n = 1'b1;
          end
        end
      end

      S_YELLOW: begin
        if (tick) begin
          if (timeLeft > TW'(1)) begin
            time_n = timeLeft - TW'(1);
          end else begin
            state_n  = S_ALLRED;
            time_n   = TW'(ALLRED_TIME);
            lights_n = '0;
            green_n  = '0;
          end
        end
      end

      S_ALLRED: begin
        if (tick) begin
          if (timeLeft > TW'(1)) begin
            time_n = timeLeft - TW'(1);
          end else if (boot_q) begin
            // Reset clearance served: ask for the first real pattern.
            state_n    = S_REQ;
            next_req_n = 1'b1;
          end else begin
            state_n  = S_GREEN;
            green_n  = pend_lights_q;
            lights_n = pend_lights_q;
            time_n   = pend_time_q;
          end
        end
      end

      default: begin
        state_n = S_ALLRED;
      end
    endcase
  end

endmodule

// File: doc/light_phase_timer.md
LIGHT_PHASE_TIMER -- requirements
Module: light_phase_timer

Interface
REQ-001 SHALL have parameter YELLOW_TIME, default 3, yellow interval in ticks (1..127).
REQ-002 SHALL have parameter ALLRED_TIME, default 1, all-red clearance interval in ticks (1..127).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port tick  input  1  one-cycle timebase enable; timers count only on tick=1.
REQ-006 SHALL have port laneOutput  input  8  requested lane pattern WWSSEENN from upstream phase generator.
REQ-007 SHALL have port loadTime  input  7  requested green duration in ticks for that pattern.
REQ-008 SHALL have port nextReq  output  1  one-cycle pulse; upstream values are sampled in this cycle.
REQ-009 SHALL have port lights  output  8  driven lamps, WWSSEENN, per 2-bit field 11=green, 01=yellow, 00=red.
REQ-010 SHALL have port timeLeft  output  7  ticks remaining in current interval.

Function
REQ-011 SHALL implement FSM states REQ, GREEN, YELLOW, ALLRED.
REQ-012 SHALL sanitise the sampled request: any 2-bit field other than 11 becomes 00.
REQ-013 SHALL treat sampled loadTime=0 as 1.
REQ-014 REQ: nextReq=1 for exactly that one cycle; tick ignored; next state decided from the sampled request.
REQ-015 REQ, sanitised request equals current green pattern: reload timeLeft=loadTime, go GREEN, lights unchanged (green extension, no yellow).
REQ-016 REQ, request differs: store as pending; if any field currently green go YELLOW (timeLeft=YELLOW_TIME), else go ALLRED (timeLeft=ALLRED_TIME).
REQ-017 YELLOW: every currently-green field SHALL show 01, all others 00.
REQ-018 ALLRED: lights=8'h00.
REQ-019 GREEN/YELLOW/ALLRED: on tick with timeLeft>1, decrement by 1; on tick with timeLeft=1, end the interval.
REQ-020 Interval end: GREEN->REQ; YELLOW->ALLRED (timeLeft=ALLRED_TIME); ALLRED->GREEN with lights=pending, timeLeft=pending loadTime.
REQ-021 GREEN with an all-red pattern SHALL still be timed normally; a following request SHALL skip YELLOW.
REQ-022 lights SHALL never go directly from 11 to 00 or from 00/01 to 11 except via REQ-015/REQ-020 paths.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-024 laneOutput/loadTime changes outside the nextReq cycle SHALL have no effect.

Reset
REQ-025 While rst=0 at a rising edge: state=ALLRED, lights=8'h00, timeLeft=ALLRED_TIME, nextReq=0, pending=8'h00 with loadTime 1.
REQ-026 Reset SHALL override any state mid-interval, including the REQ cycle; tick during reset SHALL be ignored.
REQ-027 After release, first nextReq SHALL occur in the cycle after ALLRED_TIME ticks have elapsed; the resulting GREEN SHALL be preceded by the all-red interval already served.

Configuration
REQ-028 Macro LIGHT_TIMER_HOLD_EN SHALL add input port hold (1 bit, after tick).
REQ-029 With LIGHT_TIMER_HOLD_EN defined: hold=1 in GREEN freezes timeLeft and state (ticks ignored); YELLOW/ALLRED/REQ unaffected.
REQ-030 Without LIGHT_TIMER_HOLD_EN: no hold port; behaviour as REQ-011..REQ-024.

Verification
REQ-031 Reset, tick every cycle, laneOutput=8'b11001100, loadTime=1 -> lights 00 for 1 tick, nextReq pulse, lights=11001100, timeLeft=1.
REQ-032 Alternating 11001100/00110011, loadTime=5 -> 5 ticks green, 3 ticks 01000100, 1 tick 00, then 00110011; each GREEN exactly 5 ticks.
REQ-033 Same pattern 00110011 requested twice, loadTime=4 -> no yellow/all-red; green held 8 ticks total, lights unchanged.
REQ-034 laneOutput=8'b10011101, loadTime=0 -> sanitised 00001100 green for 1 tick.
REQ-035 rst=0 during YELLOW with timeLeft=2 -> next edge lights=00, timeLeft=1, state ALLRED, nextReq=0.
REQ-036 LIGHT_TIMER_HOLD_EN defined, hold=1 for 10 ticks mid-GREEN at timeLeft=3 -> timeLeft stays 3; after release 3 more ticks of green.
